// File: rtl/ddr3_fifo_pkg.sv
// Shared types and constants for the DDR3-backed stream FIFO.
package ddr3_fifo_pkg;

  localparam int DATA_W  = 16;
  localparam int BURST_W = 128;
  localparam int WORDS   = BURST_W / DATA_W;

  localparam logic [2:0] CMD_WR = 3'd0;
  localparam logic [2:0] CMD_RD = 3'd1;

  typedef enum logic [2:0] {
    IDLE,
    WR_CMD,
    WR_DAT,
    RD_CMD,
    RD_WAIT
  } fsm_state_t;

  typedef logic [BURST_W-1:0] burst_t;

endpackage

// File: rtl/ddr3_stream_fifo_ctrl_burst_unpacker.sv
// Holds one read burst from DDR and replays it on the AXI-Stream master, lowest word first.
module burst_unpacker
  import ddr3_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  burst_t            load_data,
  input  logic              m_axis_tready,
  output logic              m_axis_tvalid,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic [3:0]        rcnt
);

  burst_t     rbuf;
  logic [2:0] idx;

  // A load only happens while rcnt is zero, so it never coincides with a handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rbuf <= '0;
      idx  <= '0;
      rcnt <= '0;
    end else if (load) begin
      rbuf <= load_data;
      idx  <= '0;
      rcnt <= 4'(WORDS);
    end else if (m_axis_tvalid && m_axis_tready) begin
      idx  <= idx + 3'd1;
      rcnt <= rcnt - 4'd1;
    end
  end

  assign m_axis_tvalid = (rcnt != 4'd0);
  assign m_axis_tdata  = rbuf[int'(idx)*DATA_W +: DATA_W];

endmodule

// File: rtl/ddr3_stream_fifo_ctrl.sv
// DDR3 ring-buffer FIFO: packs stream words into BL8 bursts, stores them in DDR, replays in order.
// Optional macro FIFO_LEVEL_EN adds a registered fifo_level output (words held in total).
module ddr3_stream_fifo_ctrl
  import ddr3_fifo_pkg::*;
#(
  parameter int ADDR_W     = 28,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_STEP  = 8,
  parameter int RING_BURST = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               init_calib_complete,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [DATA_W-1:0]  s_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               app_cmd_en,
  output logic [2:0]         app_cmd,
  output logic [ADDR_W-1:0]  app_addr,
  input  logic               app_cmd_rdy,
  output logic               app_wdata_en,
  output logic [BURST_W-1:0] app_wdata,
  output logic               app_wdata_end,
  output logic [15:0]        app_wdata_mask,
  input  logic               app_wdata_rdy,
  input  logic               app_rdata_valid,
  input  logic [BURST_W-1:0] app_rdata
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(RING_BURST*8+16):0] fifo_level
`endif
);

  localparam int PTR_W = (RING_BURST > 1) ? $clog2(RING_BURST) : 1;
  localparam int OCC_W = $clog2(RING_BURST + 1);

  fsm_state_t       state, next_state;
  burst_t           wbuf;
  logic [2:0]       wcnt;
  logic             wbuf_full;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [3:0]       rcnt;
  logic             rd_load;
  logic             wr_done;

  function automatic logic [ADDR_W-1:0] burst_addr(input logic [PTR_W-1:0] ptr);
    return ADDR_W'(BASE_ADDR) + ADDR_W'(ptr) * ADDR_W'(ADDR_STEP);
  endfunction

  assign s_axis_tready  = init_calib_complete & ~wbuf_full;
  assign app_wdata      = wbuf;
  assign app_wdata_end  = app_wdata_en;
  assign app_wdata_mask = '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wbuf      <= '0;
      wcnt      <= '0;
      wbuf_full <= 1'b0;
    end else begin
      if (s_axis_tvalid && s_axis_tready) begin
        wbuf[int'(wcnt)*DATA_W +: DATA_W] <= s_axis_tdata;
        wcnt <= wcnt + 3'd1;
        if (wcnt == 3'd7)
          wbuf_full <= 1'b1;
      end
      if (wr_done)
        wbuf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Reads win in IDLE so the output side never starves while DDR holds data.
  always_comb begin
    next_state   = state;
    app_cmd_en   = 1'b0;
    app_cmd      = CMD_WR;
    app_addr     = '0;
    app_wdata_en = 1'b0;
    rd_load      = 1'b0;
    wr_done      = 1'b0;
    case (state)
      IDLE: begin
        if (init_calib_complete) begin
          if (rcnt == 4'd0 && occ != '0)
            next_state = RD_CMD;
          else if (wbuf_full && occ != OCC_W'(RING_BURST))
            next_state = WR_CMD;
        end
      end
      WR_CMD: begin
        app_cmd_en = 1'b1;
        app_addr   = burst_addr(wr_ptr);
        if (app_cmd_rdy)
          next_state = WR_DAT;
      end
      WR_DAT: begin
        app_wdata_en = 1'b1;
        if (app_wdata_rdy) begin
          wr_done    = 1'b1;
          next_state = IDLE;
        end
      end
      RD_CMD: begin
        app_cmd_en = 1'b1;
        app_cmd    = CMD_RD;
        app_addr   = burst_addr(rd_ptr);
        if (app_cmd_rdy)
          next_state = RD_WAIT;
      end
      RD_WAIT: begin
        if (app_rdata_valid) begin
          rd_load    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else if (wr_done) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      occ    <= occ + OCC_W'(1);
    end else if (rd_load) begin
      rd_ptr <= rd_ptr + PTR_W'(1);
      occ    <= occ - OCC_W'(1);
    end
  end

  burst_unpacker u_unpacker (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (rd_load),
    .load_data     (app_rdata),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .rcnt          (rcnt)
  );

`ifdef FIFO_LEVEL_EN
  localparam int LVL_W = $clog2(RING_BURST*8+16) + 1;

  always_ff @(posedge clk) begin
    if (!rst_n)
      fifo_level <= '0;
    else
      fifo_level <= LVL_W'({occ, 3'b000})
                  + LVL_W'(wbuf_full ? 4'd8 : {1'b0, wcnt})
                  + LVL_W'(rcnt);
  end
`endif

endmodule

// File: tb/tb_ddr3_stream_fifo_ctrl.sv
// Directed bench for ddr3_stream_fifo_ctrl with a small DDR3 user-interface model (ring of 2 bursts).
module tb_ddr3_stream_fifo_ctrl;

  logic         clk;
  logic         rst_n;
  logic         init_calib_complete;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [15:0]  s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [15:0]  m_axis_tdata;
  logic         app_cmd_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_cmd_rdy;
  logic         app_wdata_en;
  logic [127:0] app_wdata;
  logic         app_wdata_end;
  logic [15:0]  app_wdata_mask;
  logic         app_wdata_rdy;
  logic         app_rdata_valid;
  logic [127:0] app_rdata;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0]  exp_q[$];
  logic [27:0]  wr_log[$];
  logic [27:0]  rd_log[$];
  logic [127:0] mem[int];
  int           rd_wait;
  logic [27:0]  rd_addr_q;
  logic [27:0]  wr_addr_q;

  ddr3_stream_fifo_ctrl #(.RING_BURST(2)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .init_calib_complete (init_calib_complete),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tdata        (s_axis_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tdata        (m_axis_tdata),
    .app_cmd_en          (app_cmd_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_cmd_rdy         (app_cmd_rdy),
    .app_wdata_en        (app_wdata_en),
    .app_wdata           (app_wdata),
    .app_wdata_end       (app_wdata_end),
    .app_wdata_mask      (app_wdata_mask),
    .app_wdata_rdy       (app_wdata_rdy),
    .app_rdata_valid     (app_rdata_valid),
    .app_rdata           (app_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DDR model: decides at the falling edge which handshakes the next rising edge completes.
  initial begin
    app_rdata_valid = 1'b0;
    app_rdata = '0;
    rd_wait = 0;
    rd_addr_q = '0;
    wr_addr_q = '0;
    forever begin
      @(negedge clk);
      app_rdata_valid = 1'b0;
      if (!rst_n) begin
        rd_wait = 0;
      end else begin
        if (rd_wait > 0) begin
          rd_wait--;
          if (rd_wait == 0) begin
            app_rdata_valid = 1'b1;
            app_rdata = mem.exists(int'(rd_addr_q)) ? mem[int'(rd_addr_q)] : '0;
          end
        end
        if (app_cmd_en && app_cmd_rdy) begin
          if (app_cmd == 3'd1) begin
            rd_addr_q = app_addr;
            rd_wait = 3;
            rd_log.push_back(app_addr);
          end else begin
            wr_addr_q = app_addr;
            wr_log.push_back(app_addr);
          end
        end
        if (app_wdata_en && app_wdata_rdy)
          mem[int'(wr_addr_q)] = app_wdata;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic calib);
    rst_n = 1'b0;
    init_calib_complete = calib;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    app_cmd_rdy = 1'b1;
    app_wdata_rdy = 1'b1;
    tick(3);
    exp_q.delete();
    wr_log.delete();
    rd_log.delete();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic send_word(input logic [15:0] d, output bit ok);
    int t = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = d;
    while (!s_axis_tready && t < 200) begin
      tick();
      t++;
    end
    ok = s_axis_tready;
    if (ok) begin
      exp_q.push_back(d);
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic recv_word(output logic [15:0] d, output bit ok);
    int t = 0;
    m_axis_tready = 1'b1;
    while (!m_axis_tvalid && t < 200) begin
      tick();
      t++;
    end
    ok = m_axis_tvalid;
    d = m_axis_tdata;
    if (ok) tick();
    m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    vectors++;
    if ({app_cmd_en, app_wdata_en, app_wdata_end, m_axis_tvalid, s_axis_tready} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b, required 00000",
               {app_cmd_en, app_wdata_en, app_wdata_end, m_axis_tvalid, s_axis_tready});
    end
    vectors++;
    if (app_addr !== 28'd0 || app_cmd !== 3'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_cmd: addr %h cmd %0d, required 0 0", app_addr, app_cmd);
    end
    vectors++;
    if (app_wdata !== 128'd0 || app_wdata_mask !== 16'd0 || m_axis_tdata !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: wdata %h mask %h tdata %h, required all 0",
               app_wdata, app_wdata_mask, m_axis_tdata);
    end
  endtask

  task automatic test_no_calib();
    do_reset(1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 16'hA5A5;
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (s_axis_tready !== 1'b0 || app_cmd_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL no_calib_cyc%0d: tready %b cmd_en %b, required 0 0", i, s_axis_tready, app_cmd_en);
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_partial_burst();
    bit ok, all_ok;
    int t;
    logic [15:0] got, exp;
    do_reset(1'b1);
    all_ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_word(16'h1000 + 16'(i), ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (app_cmd_en !== 1'b0 || m_axis_tvalid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL partial_idle_cyc%0d: cmd_en %b tvalid %b, required 0 0", i, app_cmd_en, m_axis_tvalid);
      end
      tick();
    end
    send_word(16'h1007, ok);
    all_ok &= ok;
    vectors++;
    if (!all_ok) begin
      miscompares++;
      $display("[TB] FAIL partial_send: accepted %0d words, required 8", exp_q.size());
    end
    t = 0;
    while (!m_axis_tvalid && t < 100) begin
      tick();
      t++;
    end
    vectors++;
    if (wr_log.size() != 1 || wr_log[0] !== 28'd0) begin
      miscompares++;
      $display("[TB] FAIL partial_wr_burst: %0d bursts log %p, required 1 at addr 0", wr_log.size(), wr_log);
    end
    for (int i = 0; i < 8; i++) begin
      recv_word(got, ok);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("[TB] FAIL partial_word%0d: got %h valid %b, required %h", i, got, ok, exp);
      end
    end
  endtask

  task automatic test_stream();
    bit ok, all_ok;
    int groups[4] = '{1, 6, 8, 1};
    int n;
    logic [15:0] got, exp;
    do_reset(1'b1);
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_word(16'($urandom()), ok);
      all_ok &= ok;
    end
    tick(30);
    vectors++;
    if (!all_ok || wr_log.size() != 2 || rd_log.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL stream_fill: sent_ok %b wr %0d rd %0d, required 1 2 1", all_ok, wr_log.size(), rd_log.size());
    end
    n = 0;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < groups[g]; i++) begin
        recv_word(got, ok);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
        vectors++;
        if (!ok || got !== exp) begin
          miscompares++;
          $display("[TB] FAIL stream_word%0d: got %h valid %b, required %h", n, got, ok, exp);
        end
        n++;
      end
      tick(5);
    end
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stream_empty: tvalid %b, required 0", m_axis_tvalid);
    end
    vectors++;
    if (wr_log.size() != 2 || wr_log[0] !== 28'd0 || wr_log[1] !== 28'd8 ||
        rd_log.size() != 2 || rd_log[0] !== 28'd0 || rd_log[1] !== 28'd8) begin
      miscompares++;
      $display("[TB] FAIL stream_addrs: wr %p rd %p, required wr {0,8} rd {0,8}", wr_log, rd_log);
    end
  endtask

  task automatic test_cmd_stall();
    bit ok, all_ok;
    int t;
    logic [127:0] exp_burst;
    logic [15:0] got, exp, w;
    do_reset(1'b1);
    app_cmd_rdy = 1'b0;
    app_wdata_rdy = 1'b0;
    all_ok = 1'b1;
    exp_burst = '0;
    for (int i = 0; i < 8; i++) begin
      w = 16'h0101 * 16'(i + 1) + 16'hA000;
      exp_burst[16*i +: 16] = w;
      send_word(w, ok);
      all_ok &= ok;
    end
    t = 0;
    while (!app_cmd_en && t < 50) begin
      tick();
      t++;
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (app_cmd_en !== 1'b1 || app_cmd !== 3'd0 || app_addr !== 28'd0 ||
          s_axis_tready !== 1'b0 || app_wdata_en !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_cyc%0d: cmd_en %b cmd %0d addr %h tready %b wdata_en %b, required 1 0 0 0 0",
                 i, app_cmd_en, app_cmd, app_addr, s_axis_tready, app_wdata_en);
      end
      tick();
    end
    app_cmd_rdy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (app_wdata_en !== 1'b1 || app_wdata_end !== 1'b1 || app_wdata_mask !== 16'd0 ||
          app_cmd_en !== 1'b0 || app_wdata !== exp_burst) begin
        miscompares++;
        $display("[TB] FAIL stall_wdata%0d: en %b end %b mask %h cmd_en %b data %h, required 1 1 0 0 %h",
                 i, app_wdata_en, app_wdata_end, app_wdata_mask, app_cmd_en, app_wdata, exp_burst);
      end
      tick(3);
    end
    app_wdata_rdy = 1'b1;
    vectors++;
    if (!all_ok) begin
      miscompares++;
      $display("[TB] FAIL stall_send: accepted %0d words, required 8", exp_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      recv_word(got, ok);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("[TB] FAIL stall_word%0d: got %h valid %b, required %h", i, got, ok, exp);
      end
    end
  endtask

  task automatic test_ring_full();
    bit ok, all_ok;
    logic [15:0] got, exp;
    do_reset(1'b1);
    all_ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send_word(16'h2000 + 16'(i * 3), ok);
      all_ok &= ok;
    end
    tick(20);
    vectors++;
    if (!all_ok || wr_log.size() != 3 || rd_log.size() != 1) begin
      miscompares++;
      $display("[TB] FAIL ring_fill: sent_ok %b wr %0d rd %0d, required 1 3 1", all_ok, wr_log.size(), rd_log.size());
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (s_axis_tready !== 1'b0 || app_cmd_en !== 1'b0 || m_axis_tvalid !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL ring_backpressure%0d: tready %b cmd_en %b tvalid %b, required 0 0 1",
                 i, s_axis_tready, app_cmd_en, m_axis_tvalid);
      end
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      recv_word(got, ok);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("[TB] FAIL ring_word%0d: got %h valid %b, required %h", i, got, ok, exp);
      end
    end
    vectors++;
    if (wr_log.size() != 4 || wr_log[0] !== 28'd0 || wr_log[1] !== 28'd8 ||
        wr_log[2] !== 28'd0 || wr_log[3] !== 28'd8) begin
      miscompares++;
      $display("[TB] FAIL ring_wr_wrap: wr %p, required {0,8,0,8}", wr_log);
    end
    vectors++;
    if (rd_log.size() != 4 || rd_log[0] !== 28'd0 || rd_log[1] !== 28'd8 ||
        rd_log[2] !== 28'd0 || rd_log[3] !== 28'd8) begin
      miscompares++;
      $display("[TB] FAIL ring_rd_wrap: rd %p, required {0,8,0,8}", rd_log);
    end
  endtask

  task automatic test_reset_mid_cmd();
    bit ok, all_ok;
    int t;
    logic [15:0] got, exp;
    do_reset(1'b1);
    app_cmd_rdy = 1'b0;
    for (int i = 0; i < 8; i++) send_word(16'h3000 + 16'(i), ok);
    t = 0;
    while (!app_cmd_en && t < 50) begin
      tick();
      t++;
    end
    tick(2);
    rst_n = 1'b0;
    tick();
    vectors++;
    if (app_cmd_en !== 1'b0 || app_wdata_en !== 1'b0 || m_axis_tvalid !== 1'b0 ||
        app_addr !== 28'd0 || app_wdata !== 128'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: cmd_en %b wdata_en %b tvalid %b addr %h wdata %h, required all 0",
               app_cmd_en, app_wdata_en, m_axis_tvalid, app_addr, app_wdata);
    end
    rst_n = 1'b1;
    app_cmd_rdy = 1'b1;
    exp_q.delete();
    wr_log.delete();
    rd_log.delete();
    tick();
    all_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_word(16'h4000 + 16'(i * 7), ok);
      all_ok &= ok;
    end
    for (int i = 0; i < 8; i++) begin
      recv_word(got, ok);
      exp = (exp_q.size() != 0) ? exp_q.pop_front() : 16'hxxxx;
      vectors++;
      if (!ok || got !== exp) begin
        miscompares++;
        $display("[TB] FAIL midreset_word%0d: got %h valid %b, required %h", i, got, ok, exp);
      end
    end
    vectors++;
    if (!all_ok || wr_log.size() != 1 || wr_log[0] !== 28'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_restart: sent_ok %b wr %p, required 1 {0}", all_ok, wr_log);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    init_calib_complete = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = '0;
    m_axis_tready = 1'b0;
    app_cmd_rdy = 1'b1;
    app_wdata_rdy = 1'b1;
    test_reset();
    test_no_calib();
    test_partial_burst();
    test_stream();
    test_cmd_stall();
    test_ring_full();
    test_reset_mid_cmd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
